// File: rtl/context_scheduler.sv
// Per-program run table plus round-robin selector that hands the next runnable
// user program back to the program counter with a one-cycle load strobe.
module context_scheduler #(
    parameter int NPROG      = 8,
    parameter int PW         = 3,
    parameter int FIRST_USER = 2,
    parameter int SLOT       = 200
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_req,
    input  logic [PW-1:0] load_prog,
    input  logic [31:0]   load_pc,
    input  logic          save_req,
    input  logic [PW-1:0] save_prog,
    input  logic [31:0]   save_pc,
    input  logic          end_req,
    input  logic [PW-1:0] end_prog,
    input  logic          sched_req,
    output logic [PW-1:0] next_prog,
    output logic [31:0]   next_pc,
    output logic          lpc,
    output logic          busy,
    output logic          none
);

    localparam int NUSER = NPROG - FIRST_USER;
    localparam logic [PW:0] CNT_LAST = (PW+1)'(NUSER - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    logic [NPROG-1:0] valid_q, valid_d;
    logic [31:0]      pc_q [NPROG];
    logic [31:0]      pc_d [NPROG];
    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    last_q, last_d;
    logic [PW-1:0]    cand_q, cand_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [PW-1:0]    next_prog_q, next_prog_d;
    logic [31:0]      next_pc_q, next_pc_d;
    logic             lpc_q, lpc_d;
    logic             busy_q, busy_d;
    logic             none_q, none_d;

    function automatic logic [PW-1:0] next_id(input logic [PW-1:0] x);
        if (int'(x) >= NPROG - 1 || int'(x) < FIRST_USER)
            return PW'(FIRST_USER);
        return x + PW'(1);
    endfunction

    function automatic logic writable(input logic [PW-1:0] id);
        return (int'(id) >= FIRST_USER) && (int'(id) < NPROG);
    endfunction

    // Later writes override earlier ones: save after load, end last of all.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        if (load_req && writable(load_prog)) begin
            valid_d[load_prog] = 1'b1;
            pc_d[load_prog]    = load_pc;
        end
        if (save_req && writable(save_prog) && valid_d[save_prog])
            pc_d[save_prog] = save_pc - 32'(save_prog) * 32'(SLOT);
        if (end_req && writable(end_prog))
            valid_d[end_prog] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        next_prog_d = next_prog_q;
        next_pc_d   = next_pc_q;
        lpc_d       = 1'b0;
        busy_d      = busy_q;
        none_d      = none_q;
        case (state_q)
            IDLE: begin
                if (sched_req) begin
                    none_d  = 1'b0;
                    busy_d  = 1'b1;
                    cand_d  = next_id(last_q);
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Candidate validity is the table as of the previous edge.
                if (valid_q[cand_q]) begin
                    next_prog_d = cand_q;
                    next_pc_d   = pc_q[cand_q];
                    last_d      = cand_q;
                    lpc_d       = 1'b1;
                    state_d     = ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    none_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cand_d = next_id(cand_q);
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q     <= '0;
            for (int unsigned i = 0; i < NPROG; i++)
                pc_q[i] <= '0;
            state_q     <= IDLE;
            last_q      <= PW'(NPROG - 1);
            cand_q      <= '0;
            cnt_q       <= '0;
            next_prog_q <= '0;
            next_pc_q   <= '0;
            lpc_q       <= 1'b0;
            busy_q      <= 1'b0;
            none_q      <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            state_q     <= state_d;
            last_q      <= last_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            next_prog_q <= next_prog_d;
            next_pc_q   <= next_pc_d;
            lpc_q       <= lpc_d;
            busy_q      <= busy_d;
            none_q      <= none_d;
        end
    end

    assign next_prog = next_prog_q;
    assign next_pc   = next_pc_q;
    assign lpc       = lpc_q;
    assign busy      = busy_q;
    assign none      = none_q;

endmodule

// File: tb/tb_context_scheduler.sv
// Directed bench for context_scheduler: inputs driven and outputs sampled on the falling edge.
module tb_context_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_req = 1'b0;
    logic [2:0]  load_prog = '0;
    logic [31:0] load_pc = '0;
    logic        save_req = 1'b0;
    logic [2:0]  save_prog = '0;
    logic [31:0] save_pc = '0;
    logic        end_req = 1'b0;
    logic [2:0]  end_prog = '0;
    logic        sched_req = 1'b0;
    logic [2:0]  next_prog;
    logic [31:0] next_pc;
    logic        lpc;
    logic        busy;
    logic        none;

    int total = 0;
    int bad = 0;

    context_scheduler #(.NPROG(8), .PW(3), .FIRST_USER(2), .SLOT(200)) dut (
        .clock(clock), .reset(reset),
        .load_req(load_req), .load_prog(load_prog), .load_pc(load_pc),
        .save_req(save_req), .save_prog(save_prog), .save_pc(save_pc),
        .end_req(end_req), .end_prog(end_prog),
        .sched_req(sched_req),
        .next_prog(next_prog), .next_pc(next_pc),
        .lpc(lpc), .busy(busy), .none(none)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic load(input logic [2:0] p, input logic [31:0] pc);
        load_req = 1'b1; load_prog = p; load_pc = pc;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    task automatic save(input logic [2:0] p, input logic [31:0] pc);
        save_req = 1'b1; save_prog = p; save_pc = pc;
        @(negedge clock);
        save_req = 1'b0;
    endtask

    // Fixed 16-cycle window: lat = cycles until lpc or none first seen (0 = never).
    task automatic run_sched(input int hold, output int lat, output int lpc_cnt);
        lat = 0;
        lpc_cnt = 0;
        sched_req = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clock);
            sched_req = (n < hold);
            if (lpc) lpc_cnt++;
            if (lat == 0 && (lpc || none)) lat = n;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (next_prog !== 3'd0) begin bad++; $display("FAIL reset_next_prog got=%0d want=0", next_prog); end
        total++; if (next_pc !== 32'd0) begin bad++; $display("FAIL reset_next_pc got=%0d want=0", next_pc); end
        total++; if (lpc !== 1'b0) begin bad++; $display("FAIL reset_lpc got=%b want=0", lpc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (none !== 1'b0) begin bad++; $display("FAIL reset_none got=%b want=0", none); end
    endtask

    task automatic test_single();
        int lat, cnt;
        do_reset();
        load(3'd2, 32'd5);
        run_sched(1, lat, cnt);
        total++; if (lat !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", lat); end
        total++; if (cnt !== 1) begin bad++; $display("FAIL single_lpc_width got=%0d want=1", cnt); end
        total++; if (next_prog !== 3'd2) begin bad++; $display("FAIL single_prog got=%0d want=2", next_prog); end
        total++; if (next_pc !== 32'd5) begin bad++; $display("FAIL single_pc got=%0d want=5", next_pc); end
        total++; if (none !== 1'b0) begin bad++; $display("FAIL single_none got=%b want=0", none); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_round_robin();
        int lat, cnt;
        do_reset();
        load(3'd2, 32'd0);
        load(3'd4, 32'd7);
        run_sched(1, lat, cnt);
        total++; if (lat !== 2 || next_prog !== 3'd2) begin bad++; $display("FAIL rr_first got lat=%0d prog=%0d want lat=2 prog=2", lat, next_prog); end
        run_sched(1, lat, cnt);
        total++; if (lat !== 3 || next_prog !== 3'd4 || next_pc !== 32'd7) begin bad++; $display("FAIL rr_second got lat=%0d prog=%0d pc=%0d want lat=3 prog=4 pc=7", lat, next_prog, next_pc); end
        run_sched(1, lat, cnt);
        total++; if (lat !== 5 || next_prog !== 3'd2 || next_pc !== 32'd0) begin bad++; $display("FAIL rr_wrap got lat=%0d prog=%0d pc=%0d want lat=5 prog=2 pc=0", lat, next_prog, next_pc); end
        total++; if (cnt !== 1) begin bad++; $display("FAIL rr_lpc_width got=%0d want=1", cnt); end
    endtask

    task automatic test_save();
        int lat, cnt;
        do_reset();
        load(3'd3, 32'd0);
        save(3'd3, 32'd612);
        save(3'd5, 32'd1000);
        run_sched(1, lat, cnt);
        total++; if (lat !== 3 || next_prog !== 3'd3) begin bad++; $display("FAIL save_grant got lat=%0d prog=%0d want lat=3 prog=3", lat, next_prog); end
        total++; if (next_pc !== 32'd12) begin bad++; $display("FAIL save_relative_pc got=%0d want=12", next_pc); end
        run_sched(1, lat, cnt);
        total++; if (lat !== 7 || next_prog !== 3'd3) begin bad++; $display("FAIL save_invalid_slot_skipped got lat=%0d prog=%0d want lat=7 prog=3", lat, next_prog); end
    endtask

    task automatic test_save_end_same();
        int lat, cnt;
        do_reset();
        load(3'd3, 32'd44);
        save_req = 1'b1; save_prog = 3'd3; save_pc = 32'd700;
        end_req = 1'b1; end_prog = 3'd3;
        @(negedge clock);
        save_req = 1'b0; end_req = 1'b0;
        run_sched(1, lat, cnt);
        total++; if (lat !== 7) begin bad++; $display("FAIL saveend_none_latency got=%0d want=7", lat); end
        total++; if (cnt !== 0) begin bad++; $display("FAIL saveend_no_lpc got=%0d want=0", cnt); end
        total++; if (none !== 1'b1) begin bad++; $display("FAIL saveend_none got=%b want=1", none); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL saveend_busy got=%b want=0", busy); end
        total++; if (next_prog !== 3'd0) begin bad++; $display("FAIL saveend_prog_held got=%0d want=0", next_prog); end
    endtask

    task automatic test_sched_during_scan();
        int lat, cnt;
        do_reset();
        load(3'd6, 32'd9);
        run_sched(4, lat, cnt);
        total++; if (cnt !== 1) begin bad++; $display("FAIL busy_sched_lpc_count got=%0d want=1", cnt); end
        total++; if (lat !== 6 || next_prog !== 3'd6 || next_pc !== 32'd9) begin bad++; $display("FAIL busy_sched_grant got lat=%0d prog=%0d pc=%0d want lat=6 prog=6 pc=9", lat, next_prog, next_pc); end
    endtask

    task automatic test_reset_mid_scan();
        int lat, cnt, seen;
        seen = 0;
        sched_req = 1'b1;
        @(negedge clock);
        sched_req = 1'b0;
        @(negedge clock);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midscan_busy got=%b want=1", busy); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (lpc) seen++;
            @(negedge clock);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midscan_lpc got=%0d want=0", seen); end
        total++; if (next_prog !== 3'd0 || next_pc !== 32'd0) begin bad++; $display("FAIL midscan_outputs got prog=%0d pc=%0d want 0 0", next_prog, next_pc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midscan_busy_after got=%b want=0", busy); end
        run_sched(1, lat, cnt);
        total++; if (lat !== 7 || cnt !== 0 || none !== 1'b1) begin bad++; $display("FAIL midscan_table_cleared got lat=%0d lpc=%0d none=%b want lat=7 lpc=0 none=1", lat, cnt, none); end
    endtask

    task automatic test_low_ids();
        int lat, cnt;
        do_reset();
        load(3'd1, 32'd3);
        load(3'd0, 32'd4);
        run_sched(1, lat, cnt);
        total++; if (lat !== 7 || cnt !== 0) begin bad++; $display("FAIL lowid_ignored got lat=%0d lpc=%0d want lat=7 lpc=0", lat, cnt); end
        total++; if (none !== 1'b1) begin bad++; $display("FAIL lowid_none got=%b want=1", none); end
        sched_req = 1'b1;
        @(negedge clock);
        sched_req = 1'b0;
        total++; if (none !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL lowid_none_clear got none=%b busy=%b want 0 1", none, busy); end
        repeat (10) @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_round_robin();
        test_save();
        test_save_end_same();
        test_sched_during_scan();
        test_reset_mid_scan();
        test_low_ids();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
